// File: rtl/alu21_core.sv
// Registered 21-bit integer ALU for the execute stage: one opcode-selected
// result per clock, with a zero flag derived from the same next value as C.
module alu21_core #(
    parameter int WIDTH = 21,
    parameter int OPW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [OPW-1:0]   sel,
    output logic [WIDTH-1:0] C,
    output logic             flagZ
);

    localparam logic [OPW-1:0] OP_AND = OPW'(5'd1);
    localparam logic [OPW-1:0] OP_OR  = OPW'(5'd2);
    localparam logic [OPW-1:0] OP_ADD = OPW'(5'd3);
    localparam logic [OPW-1:0] OP_XOR = OPW'(5'd4);
    localparam logic [OPW-1:0] OP_SUB = OPW'(5'd5);
    localparam logic [OPW-1:0] OP_SLL = OPW'(5'd6);
    localparam logic [OPW-1:0] OP_SRL = OPW'(5'd7);
    localparam logic [OPW-1:0] OP_SRA = OPW'(5'd8);
    localparam logic [OPW-1:0] OP_MUL = OPW'(5'd9);
    localparam logic [OPW-1:0] OP_DIV = OPW'(5'd10);
    localparam logic [OPW-1:0] OP_MOD = OPW'(5'd11);
    localparam logic [OPW-1:0] OP_SLT = OPW'(5'd12);
    localparam logic [OPW-1:0] OP_MOV = OPW'(5'd13);
    localparam logic [OPW-1:0] OP_NOT = OPW'(5'd14);

    // Shift amount is the low five bits of B; amounts past the width saturate.
    localparam logic [4:0] SH_LIM = 5'(WIDTH);

    logic [4:0]       amt;
    logic             sh_over;
    logic [WIDTH-1:0] sll_res, srl_res, sra_res;
    logic [WIDTH-1:0] mul_res, div_res, mod_res, slt_res;
    logic [WIDTH-1:0] res;

    assign amt     = B[4:0];
    assign sh_over = (amt >= SH_LIM);

    assign sll_res = sh_over ? '0 : (A << amt);
    assign srl_res = sh_over ? '0 : (A >> amt);
    assign sra_res = sh_over ? {WIDTH{A[WIDTH-1]}} : WIDTH'($signed(A) >>> amt);

    assign mul_res = A * B;
    // Divide by zero returns all-ones for the quotient and passes A as remainder.
    assign div_res = (B == '0) ? '1 : (A / B);
    assign mod_res = (B == '0) ? A  : (A % B);
    assign slt_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};

    always_comb begin
        res = '0;
        case (sel)
            OP_AND:  res = A & B;
            OP_OR:   res = A | B;
            OP_ADD:  res = A + B;
            OP_XOR:  res = A ^ B;
            OP_SUB:  res = A - B;
            OP_SLL:  res = sll_res;
            OP_SRL:  res = srl_res;
            OP_SRA:  res = sra_res;
            OP_MUL:  res = mul_res;
            OP_DIV:  res = div_res;
            OP_MOD:  res = mod_res;
            OP_SLT:  res = slt_res;
            OP_MOV:  res = B;
            OP_NOT:  res = ~A;
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            C     <= '0;
            flagZ <= 1'b1;
        end else begin
            C     <= res;
            flagZ <= (res == '0);
        end
    end

endmodule

// File: tb/tb_alu21_core.sv
// Scoreboard bench for alu21_core: stimulus queues hand-computed results,
// a monitor pops one expectation per rising edge and compares C/flagZ.
module tb_alu21_core;

    logic        clk;
    logic        rst_n;
    logic [20:0] A, B;
    logic [4:0]  sel;
    logic [20:0] C;
    logic        flagZ;

    typedef struct {
        logic [20:0] c;
        logic        z;
        int          id;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_vec = 0;

    alu21_core #(.WIDTH(21), .OPW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .sel   (sel),
        .C     (C),
        .flagZ (flagZ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [20:0] act_c, input logic act_z,
                         input logic [20:0] exp_c, input logic exp_z);
        n_cmp++;
        if (act_c !== exp_c || act_z !== exp_z) begin
            n_bad++;
            $display("FAIL %s: got C=%h flagZ=%b, want C=%h flagZ=%b",
                     name, act_c, act_z, exp_c, exp_z);
        end
    endtask

    // Drive a vector on the falling edge; its result is due after the next rising edge.
    task automatic apply(input logic [4:0] op, input logic [20:0] a, input logic [20:0] b,
                         input logic [20:0] exp_c);
        exp_t e;
        @(negedge clk);
        A = a; B = b; sel = op;
        e.c  = exp_c;
        e.z  = (exp_c == 21'd0);
        e.id = n_vec++;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("vec%0d", e.id), C, flagZ, e.c, e.z);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1; A = 21'd5; B = 21'd10; sel = 5'b00011;
        // One edge loads 15, then reset is asserted between edges.
        #7 rst_n = 1'b0;
        #1 check("async_reset", C, flagZ, 21'd0, 1'b1);

        @(negedge clk);
        rst_n = 1'b1;
        begin
            exp_t e;
            e.c = 21'd15; e.z = 1'b0; e.id = n_vec++;
            exp_q.push_back(e);
        end

        apply(5'b00011, 21'd5,       21'd10,      21'd15);
        apply(5'b00101, 21'd15,      21'd5,       21'd10);
        apply(5'b00011, 21'd5,       21'h1FFFFB,  21'd0);
        apply(5'b00101, 21'd0,       21'd1,       21'h1FFFFF);
        apply(5'b00101, 21'd5,       21'd15,      21'h1FFFF6);
        apply(5'b00001, 21'h00F0F0,  21'h00FF00,  21'h00F000);
        apply(5'b00010, 21'h00F0F0,  21'h00FF00,  21'h00FFF0);
        apply(5'b00100, 21'h00F0F0,  21'h00FF00,  21'h000FF0);
        apply(5'b01001, 21'd3,       21'd7,       21'd21);
        apply(5'b01010, 21'd20,      21'd4,       21'd5);
        apply(5'b01011, 21'd20,      21'd6,       21'd2);
        apply(5'b01001, 21'h001000,  21'h001000,  21'd0);
        apply(5'b01010, 21'd20,      21'd0,       21'h1FFFFF);
        apply(5'b01011, 21'd20,      21'd0,       21'd20);
        apply(5'b01000, 21'h100000,  21'd4,       21'h1F0000);
        apply(5'b00111, 21'h100000,  21'd4,       21'h010000);
        apply(5'b00110, 21'd1,       21'd21,      21'd0);
        apply(5'b00110, 21'd3,       21'd4,       21'h000030);
        apply(5'b00110, 21'd1,       21'd20,      21'h100000);
        apply(5'b00110, 21'd1,       21'h000022,  21'd4);
        apply(5'b01000, 21'h100000,  21'd25,      21'h1FFFFF);
        apply(5'b01000, 21'h0FFFFF,  21'd21,      21'd0);
        apply(5'b00111, 21'h1FFFFF,  21'd31,      21'd0);
        apply(5'b01100, 21'h1FFFFF,  21'd1,       21'd1);
        apply(5'b01100, 21'd1,       21'h1FFFFF,  21'd0);
        apply(5'b01100, 21'd3,       21'd5,       21'd1);
        apply(5'b01101, 21'd0,       21'h012345,  21'h012345);
        apply(5'b01110, 21'h00F0F0,  21'd0,       21'h1F0F0F);
        apply(5'b11111, 21'd5,       21'd10,      21'd0);
        apply(5'b00000, 21'd5,       21'd10,      21'd0);
        apply(5'b01111, 21'd5,       21'd10,      21'd0);
        apply(5'b00011, 21'd1,       21'd1,       21'd2);

        @(posedge clk);
        #3;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end

        // Reset asserted mid-cycle while a result is held, then released.
        @(negedge clk);
        A = 21'h7; B = 21'h3; sel = 5'b00001;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("reset_mid", C, flagZ, 21'd0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            exp_t e;
            e.c = 21'd3; e.z = 1'b0; e.id = n_vec++;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #3;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL final_drain: got %0d pending, want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu21_core.md
Name: alu21_core

Overview:
21-bit registered integer ALU for the processor execute stage. Selects one of a fixed set of arithmetic/logic/shift operations on operands A and B via a 5-bit opcode. Registers the 21-bit result C and zero flag flagZ once per clock. Downstream writeback and branch logic consume C and flagZ one cycle after operands and opcode are presented.

Parameters:
WIDTH, 21, data width of A, B, C (all arithmetic defined modulo 2^WIDTH)
OPW, 5, opcode width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
A  input  21  operand A
B  input  21  operand B (shift amount taken from B[4:0])
sel  input  5  opcode
C  output  21  registered result
flagZ  output  1  registered zero flag, 1 when C == 0

Behaviour:
- One clock; reset is asynchronous and active-low: rst_n low forces C = 0 and flagZ = 1 immediately, independent of clk.
- Latency 1: the result of A/B/sel sampled at rising edge N appears on C/flagZ after edge N. Both update every cycle, with no enable and no handshake.
- flagZ is computed from the same next-result value that is loaded into C. It is never stale relative to C.
- Opcode map (sel):
  - 00001 AND: A & B
  - 00010 OR: A | B
  - 00011 ADD: A + B, wraps mod 2^21. 5 + 0x1FFFFB gives 0.
  - 00100 XOR: A ^ B
  - 00101 SUB: A - B, wraps mod 2^21. 5 - 15 gives 0x1FFFF6.
  - 00110 SLL: A << B[4:0]
  - 00111 SRL: A >> B[4:0], logical
  - 01000 SRA: A >>> B[4:0], arithmetic, sign = A[20]
  - 01001 MUL: low 21 bits of A*B (signedness irrelevant for low bits)
  - 01010 DIV: unsigned A / B, truncating
  - 01011 MOD: unsigned A % B
  - 01100 SLT: 1 if A < B as signed two's complement, else 0
  - 01101 MOV: B
  - 01110 NOT: ~A
  - all other codes, including 00000: C = 0, flagZ = 1
- Shift amount B[4:0] ≥ 21: SLL/SRL give 0; SRA gives 0x1FFFFF if A[20]=1, else 0.
- Divide by zero (B == 0): DIV gives 0x1FFFFF; MOD gives A.
- No carry/overflow outputs. Overflow bits are discarded silently.
- Fully synthesizable. DIV/MOD/MUL are single-cycle combinational before the output register.
- Releasing reset mid-operation: the first edge after release loads the current inputs' result normally.

Test Plan:
- Reset: assert rst_n=0 with A=5, B=10, sel=00011 → C=0, flagZ=1 without a clock edge. Release, one edge → C=15, flagZ=0.
- ADD/SUB: A=5, B=10, ADD → C=15. A=15, B=5, SUB → C=10. A=5, B=0x1FFFFB, ADD → C=0, flagZ=1. A=0, B=1, SUB → C=0x1FFFFF.
- MUL/DIV/MOD: A=3, B=7, MUL → C=21. A=20, B=4, DIV → C=5. A=20, B=6, MOD → C=2. A=0x1000, B=0x1000, MUL → C=0 (truncated), flagZ=1.
- Divide by zero: A=20, B=0, DIV → C=0x1FFFFF. MOD → C=20.
- Shifts/compare: A=0x100000, B=4, SRA → C=0x1F0000. SRL → C=0x010000. A=1, B=21, SLL → C=0. A=0x1FFFFF(-1), B=1, SLT → C=1. Swap operands → C=0, flagZ=1.
- Latency/undefined opcode: change inputs every cycle and check C lags by exactly one edge. sel=11111 → C=0, flagZ=1.
